// File: rtl/tile_rasterizer.sv
// ============================================================================
// Module   : tile_rasterizer
// Brief    : Scans one TILE_DIM x TILE_DIM tile, LANES pixels per cycle, and
//            emits masked flat-colour writes for one triangle clipped to a box.
//            Optional macro BACKFACE_CULL_EN rejects clockwise (A<0) triangles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tile_rasterizer #(
    parameter int TILE_DIM = 8,
    parameter int LANES    = 4,
    parameter int COORD_W  = 10,
    parameter int COLOR_W  = 16
) (
    input  logic                        BOARD_CLK,
    input  logic                        RESET_N,
    input  logic                        start,
    input  logic                        tile_buf_sel,
    input  logic [COORD_W-1:0]          tile_off_x,
    input  logic [COORD_W-1:0]          tile_off_y,
    input  logic [COORD_W-1:0]          x0,
    input  logic [COORD_W-1:0]          y0,
    input  logic [COORD_W-1:0]          x1,
    input  logic [COORD_W-1:0]          y1,
    input  logic [COORD_W-1:0]          x2,
    input  logic [COORD_W-1:0]          y2,
    input  logic [COORD_W-1:0]          box_x,
    input  logic [COORD_W-1:0]          box_y,
    input  logic [COORD_W-1:0]          box_w,
    input  logic [COORD_W-1:0]          box_h,
    input  logic [COLOR_W-1:0]          tri_color,
    output logic                        busy,
    output logic                        done,
    output logic                        wr_en,
    output logic                        wr_buf,
    output logic [$clog2(TILE_DIM)-1:0] wr_x,
    output logic [$clog2(TILE_DIM)-1:0] wr_y,
    output logic [LANES-1:0]            wr_mask,
    output logic [COLOR_W-1:0]          wr_color
);

    localparam int LW  = $clog2(TILE_DIM);
    localparam int CW1 = COORD_W + 1;
    localparam int EW  = 2 * COORD_W + 4;
    localparam logic [LW-1:0]  LAST_X   = LW'(TILE_DIM - LANES);
    localparam logic [LW-1:0]  LAST_Y   = LW'(TILE_DIM - 1);
    localparam logic [LW-1:0]  X_STEP   = LW'(LANES);
    localparam logic [CW1-1:0] TILE_EXT = CW1'(TILE_DIM);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_RASTER = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               state_q;
    logic [COORD_W-1:0]   off_x_q, off_y_q;
    logic [COORD_W-1:0]   x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
    logic [COORD_W-1:0]   box_x_q, box_y_q, box_w_q, box_h_q;
    logic                 ccw_q;
    logic [LW-1:0]        lx_q, ly_q;

    function automatic logic signed [EW-1:0] sext(input logic [CW1-1:0] v);
        return $signed({{(EW-CW1){1'b0}}, v});
    endfunction

    logic signed [EW-1:0] w_sx0, w_sy0, w_sx1, w_sy1, w_sx2, w_sy2;
    logic signed [EW-1:0] w_dx01, w_dy01, w_dx12, w_dy12, w_dx20, w_dy20;
    logic signed [EW-1:0] w_area;

    assign w_sx0  = sext({1'b0, x0_q});
    assign w_sy0  = sext({1'b0, y0_q});
    assign w_sx1  = sext({1'b0, x1_q});
    assign w_sy1  = sext({1'b0, y1_q});
    assign w_sx2  = sext({1'b0, x2_q});
    assign w_sy2  = sext({1'b0, y2_q});
    assign w_dx01 = w_sx1 - w_sx0;
    assign w_dy01 = w_sy1 - w_sy0;
    assign w_dx12 = w_sx2 - w_sx1;
    assign w_dy12 = w_sy2 - w_sy1;
    assign w_dx20 = w_sx0 - w_sx2;
    assign w_dy20 = w_sy0 - w_sy2;
    assign w_area = w_dx01 * (w_sy2 - w_sy0) - w_dy01 * (w_sx2 - w_sx0);

    // Box/tile intersection only decides early reject; per-pixel box test does the clipping.
    logic [CW1-1:0] w_box_x_end, w_box_y_end, w_tile_x_end, w_tile_y_end;
    logic [CW1-1:0] w_lo_x, w_hi_x, w_lo_y, w_hi_y;
    logic           w_clip_empty, w_area_zero, w_reject;

    assign w_box_x_end  = {1'b0, box_x_q} + {1'b0, box_w_q};
    assign w_box_y_end  = {1'b0, box_y_q} + {1'b0, box_h_q};
    assign w_tile_x_end = {1'b0, off_x_q} + TILE_EXT;
    assign w_tile_y_end = {1'b0, off_y_q} + TILE_EXT;
    assign w_lo_x = (box_x_q >= off_x_q) ? {1'b0, box_x_q} : {1'b0, off_x_q};
    assign w_lo_y = (box_y_q >= off_y_q) ? {1'b0, box_y_q} : {1'b0, off_y_q};
    assign w_hi_x = (w_box_x_end <= w_tile_x_end) ? w_box_x_end : w_tile_x_end;
    assign w_hi_y = (w_box_y_end <= w_tile_y_end) ? w_box_y_end : w_tile_y_end;
    assign w_clip_empty = (w_lo_x >= w_hi_x) || (w_lo_y >= w_hi_y);
    assign w_area_zero  = (w_area == '0);

`ifdef BACKFACE_CULL_EN
    assign w_reject = w_area_zero || w_area[EW-1] || w_clip_empty;
`else
    assign w_reject = w_area_zero || w_clip_empty;
`endif

    logic [CW1-1:0]       w_py;
    logic signed [EW-1:0] w_py_s;
    logic                 w_py_in;
    logic [LANES-1:0]     w_mask;

    assign w_py    = {1'b0, off_y_q} + CW1'(ly_q);
    assign w_py_s  = sext(w_py);
    assign w_py_in = (w_py >= {1'b0, box_y_q}) && (w_py < w_box_y_end);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam logic [CW1-1:0] LANE_OFS = CW1'(i);
        logic [CW1-1:0]       w_px;
        logic signed [EW-1:0] w_px_s, w_e01, w_e12, w_e20;
        logic                 w_in_box, w_all_neg, w_all_pos;

        assign w_px   = {1'b0, off_x_q} + CW1'(lx_q) + LANE_OFS;
        assign w_px_s = sext(w_px);
        assign w_e01  = (w_px_s - w_sx0) * w_dy01 - (w_py_s - w_sy0) * w_dx01;
        assign w_e12  = (w_px_s - w_sx1) * w_dy12 - (w_py_s - w_sy1) * w_dx12;
        assign w_e20  = (w_px_s - w_sx2) * w_dy20 - (w_py_s - w_sy2) * w_dx20;
        assign w_in_box  = w_py_in && (w_px >= {1'b0, box_x_q}) && (w_px < w_box_x_end);
        assign w_all_neg = w_e01[EW-1] && w_e12[EW-1] && w_e20[EW-1];
        assign w_all_pos = !w_e01[EW-1] && (w_e01 != '0) &&
                           !w_e12[EW-1] && (w_e12 != '0) &&
                           !w_e20[EW-1] && (w_e20 != '0);
        assign w_mask[i] = w_in_box && (ccw_q ? w_all_neg : w_all_pos);
    end

    always_ff @(posedge BOARD_CLK) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_en    <= 1'b0;
            wr_buf   <= 1'b0;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_mask  <= '0;
            wr_color <= '0;
            off_x_q  <= '0;
            off_y_q  <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            x2_q     <= '0;
            y2_q     <= '0;
            box_x_q  <= '0;
            box_y_q  <= '0;
            box_w_q  <= '0;
            box_h_q  <= '0;
            ccw_q    <= 1'b0;
            lx_q     <= '0;
            ly_q     <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        off_x_q  <= tile_off_x;
                        off_y_q  <= tile_off_y;
                        x0_q     <= x0;
                        y0_q     <= y0;
                        x1_q     <= x1;
                        y1_q     <= y1;
                        x2_q     <= x2;
                        y2_q     <= y2;
                        box_x_q  <= box_x;
                        box_y_q  <= box_y;
                        box_w_q  <= box_w;
                        box_h_q  <= box_h;
                        wr_buf   <= tile_buf_sel;
                        wr_color <= tri_color;
                        busy     <= 1'b1;
                        state_q  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    ccw_q   <= !w_area[EW-1];
                    lx_q    <= '0;
                    ly_q    <= '0;
                    state_q <= w_reject ? S_DONE : S_RASTER;
                end
                S_RASTER: begin
                    wr_en   <= 1'b1;
                    wr_x    <= lx_q;
                    wr_y    <= ly_q;
                    wr_mask <= w_mask;
                    lx_q    <= lx_q + X_STEP;
                    if (lx_q == LAST_X) begin
                        ly_q <= ly_q + LW'(1);
                        if (ly_q == LAST_Y) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
